// File: rtl/vga_pkg.sv
// Shared raster timing constants for the VGA output path (640x480 at 60 Hz defaults).
package vga_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Sync windows are half-open: [START, END).
   localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   localparam int unsigned COLOR_W   = 6;
   localparam int unsigned POS_W     = 10;
   localparam int unsigned FC_W      = 10;
   localparam int unsigned MAX_TOTAL = 1 << POS_W;

   function automatic logic in_window(input int unsigned pos, input int unsigned lo,
                                      input int unsigned hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/active flags decoded from the
// next position, so flags and position always describe the same point.
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned VIS         = H_VISIBLE,
   parameter int unsigned FRONT       = H_FRONT,
   parameter int unsigned SYNC        = H_SYNC,
   parameter int unsigned BACK        = H_BACK,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step_i,
   output logic [POS_W-1:0] pos_o,
   output logic             sync_o,
   output logic             active_o,
   output logic             wrap_o
);

   localparam int unsigned      TOTAL   = VIS + FRONT + SYNC + BACK;
   localparam int unsigned      S_START = VIS + FRONT;
   localparam int unsigned      S_END   = S_START + SYNC;
   localparam logic [POS_W-1:0] LAST    = POS_W'(TOTAL - 1);

   logic [POS_W-1:0] pos_d, pos_q;
   logic             sync_d, sync_q;
   logic             active_d, active_q;

   // Combinational so the next axis can step on the same edge.
   assign wrap_o = step_i && (pos_q == LAST);

   always_comb begin
      pos_d = pos_q;
      if (step_i) begin
         pos_d = wrap_o ? '0 : pos_q + POS_W'(1);
      end
      sync_d   = in_window(32'(pos_d), S_START, S_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      active_d = 32'(pos_d) < VIS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q    <= '0;
         sync_q   <= ~SYNC_ACTIVE;
         active_q <= (VIS != 0);
      end else begin
         pos_q    <= pos_d;
         sync_q   <= sync_d;
         active_q <= active_d;
      end
   end

   assign pos_o    = pos_q;
   assign sync_o   = sync_q;
   assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: chained horizontal/vertical axis counters plus line/frame strobes
// and a running frame counter.
module vga_timing_gen
   import vga_pkg::POS_W, vga_pkg::FC_W, vga_pkg::MAX_TOTAL;
#(
   parameter int unsigned H_VISIBLE   = vga_pkg::H_VISIBLE,
   parameter int unsigned H_FRONT     = vga_pkg::H_FRONT,
   parameter int unsigned H_SYNC      = vga_pkg::H_SYNC,
   parameter int unsigned H_BACK      = vga_pkg::H_BACK,
   parameter int unsigned V_VISIBLE   = vga_pkg::V_VISIBLE,
   parameter int unsigned V_FRONT     = vga_pkg::V_FRONT,
   parameter int unsigned V_SYNC      = vga_pkg::V_SYNC,
   parameter int unsigned V_BACK      = vga_pkg::V_BACK,
   parameter bit          SYNC_ACTIVE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   output logic [POS_W-1:0] hpos_o,
   output logic [POS_W-1:0] vpos_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             visible_o,
   output logic             line_start_o,
   output logic             frame_start_o,
   output logic [FC_W-1:0]  frame_count_o
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : gen_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic h_wrap, v_wrap, h_active, v_active;

   vga_axis_counter #(
      .VIS         (H_VISIBLE),
      .FRONT       (H_FRONT),
      .SYNC        (H_SYNC),
      .BACK        (H_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_h_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_i   (en_i),
      .pos_o    (hpos_o),
      .sync_o   (hsync_o),
      .active_o (h_active),
      .wrap_o   (h_wrap)
   );

   vga_axis_counter #(
      .VIS         (V_VISIBLE),
      .FRONT       (V_FRONT),
      .SYNC        (V_SYNC),
      .BACK        (V_BACK),
      .SYNC_ACTIVE (SYNC_ACTIVE)
   ) u_v_axis (
      .clk      (clk),
      .rst_n    (rst_n),
      .step_i   (h_wrap),
      .pos_o    (vpos_o),
      .sync_o   (vsync_o),
      .active_o (v_active),
      .wrap_o   (v_wrap)
   );

   logic            line_start_d, line_start_q;
   logic            frame_start_d, frame_start_q;
   logic [FC_W-1:0] frame_count_d, frame_count_q;

   // v_wrap already implies h_wrap, so it marks the (0,0) wrap.
   always_comb begin
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
      frame_count_d = frame_count_q + FC_W'(v_wrap);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
      end else begin
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign visible_o     = h_active & v_active;
   assign line_start_o  = line_start_q;
   assign frame_start_o = frame_start_q;
   assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x525 timing, an 8x525 build for vertical/frame behaviour,
// and an 8x4 build for frame-counter wrap and asynchronous reset.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Instance a: default 640x480 timing.
   logic       rst_a, en_a, hs_a, vs_a, vis_a, ls_a, fs_a;
   logic [9:0] hpos_a, vpos_a, fc_a;

   vga_timing_gen u_dut_a (
      .clk           (clk),
      .rst_n         (rst_a),
      .en_i          (en_a),
      .hpos_o        (hpos_a),
      .vpos_o        (vpos_a),
      .hsync_o       (hs_a),
      .vsync_o       (vs_a),
      .visible_o     (vis_a),
      .line_start_o  (ls_a),
      .frame_start_o (fs_a),
      .frame_count_o (fc_a)
   );

   // Instance b: 8-pixel lines (hsync on 5..6), default vertical timing.
   logic       rst_b, en_b, hs_b, vs_b, vis_b, ls_b, fs_b;
   logic [9:0] hpos_b, vpos_b, fc_b;

   vga_timing_gen #(
      .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1)
   ) u_dut_b (
      .clk           (clk),
      .rst_n         (rst_b),
      .en_i          (en_b),
      .hpos_o        (hpos_b),
      .vpos_o        (vpos_b),
      .hsync_o       (hs_b),
      .vsync_o       (vs_b),
      .visible_o     (vis_b),
      .line_start_o  (ls_b),
      .frame_start_o (fs_b),
      .frame_count_o (fc_b)
   );

   // Instance c: 8x4 totals, vsync on line 3.
   logic       rst_c, en_c, hs_c, vs_c, vis_c, ls_c, fs_c;
   logic [9:0] hpos_c, vpos_c, fc_c;

   vga_timing_gen #(
      .H_VISIBLE (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
      .V_VISIBLE (2), .V_FRONT (1), .V_SYNC (1), .V_BACK (0)
   ) u_dut_c (
      .clk           (clk),
      .rst_n         (rst_c),
      .en_i          (en_c),
      .hpos_o        (hpos_c),
      .vpos_o        (vpos_c),
      .hsync_o       (hs_c),
      .vsync_o       (vs_c),
      .visible_o     (vis_c),
      .line_start_o  (ls_c),
      .frame_start_o (fs_c),
      .frame_count_o (fc_c)
   );

   int unsigned vs_low;
   logic        vis_or;
   int          en_seq  [4] = '{1, 0, 0, 1};
   int          hpos_seq[4] = '{101, 101, 101, 102};

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      en_a  = 1'b1; en_b  = 1'b1; en_c  = 1'b1;

      // ---- Instance a: reset and horizontal behaviour ----
      repeat (5) @(negedge clk);
      check_eq("a_rst_hpos", hpos_a, 0);
      check_eq("a_rst_vpos", vpos_a, 0);
      check_eq("a_rst_hsync", hs_a, 1);
      check_eq("a_rst_vsync", vs_a, 1);
      check_eq("a_rst_visible", vis_a, 1);
      check_eq("a_rst_line_start", ls_a, 0);
      check_eq("a_rst_frame_start", fs_a, 0);
      check_eq("a_rst_frame_count", fc_a, 0);
      rst_a = 1'b1;
      @(negedge clk);
      check_eq("a_release_hpos", hpos_a, 1);
      check_eq("a_release_line_start", ls_a, 0);

      repeat (638) @(negedge clk);
      check_eq("a_hpos639", hpos_a, 639);
      check_eq("a_vis639", vis_a, 1);
      @(negedge clk);
      check_eq("a_vis640", vis_a, 0);
      repeat (15) @(negedge clk);
      check_eq("a_hs655", hs_a, 1);
      @(negedge clk);
      check_eq("a_hs656", hs_a, 0);
      repeat (95) @(negedge clk);
      check_eq("a_hs751", hs_a, 0);
      @(negedge clk);
      check_eq("a_hpos752", hpos_a, 752);
      check_eq("a_hs752", hs_a, 1);

      // (752,0) -> (799,10)
      repeat (47 + 10 * 800) @(negedge clk);
      check_eq("a_pre_wrap_hpos", hpos_a, 799);
      check_eq("a_pre_wrap_vpos", vpos_a, 10);
      check_eq("a_pre_wrap_ls", ls_a, 0);
      @(negedge clk);
      check_eq("a_wrap_hpos", hpos_a, 0);
      check_eq("a_wrap_vpos", vpos_a, 11);
      check_eq("a_wrap_ls", ls_a, 1);
      check_eq("a_wrap_fs", fs_a, 0);
      check_eq("a_wrap_vis", vis_a, 1);
      @(negedge clk);
      check_eq("a_ls_one_cycle", ls_a, 0);

      // Enable gating at hpos 100.
      repeat (99) @(negedge clk);
      check_eq("a_gate_start", hpos_a, 100);
      for (int i = 0; i < 4; i++) begin
         en_a = en_seq[i][0];
         @(negedge clk);
         check_eq($sformatf("a_gate_hpos%0d", i), hpos_a, hpos_seq[i]);
         check_eq($sformatf("a_gate_ls%0d", i), ls_a, 0);
      end
      en_a = 1'b1;
      repeat (697) @(negedge clk);
      check_eq("a_hold799_hpos", hpos_a, 799);
      en_a = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("a_hold799_hpos2", hpos_a, 799);
      check_eq("a_hold799_vpos", vpos_a, 11);
      check_eq("a_hold799_ls", ls_a, 0);
      en_a = 1'b1;
      @(negedge clk);
      check_eq("a_resume_hpos", hpos_a, 0);
      check_eq("a_resume_vpos", vpos_a, 12);
      check_eq("a_resume_ls", ls_a, 1);
      rst_a = 1'b0;

      // ---- Instance b: vertical windows and frame wrap; position k = v*8+h ----
      vs_low = 0;
      vis_or = 1'b0;
      rst_b  = 1'b1;
      for (int k = 1; k <= 4208; k++) begin
         @(negedge clk);
         if (vs_b == 1'b0) vs_low++;
         if (k >= 480 * 8 && k < 481 * 8) vis_or = vis_or | vis_b;
         case (k)
            4:          check_eq("b_hs4", hs_b, 1);
            5:          check_eq("b_hs5", hs_b, 0);
            8: begin
               check_eq("b_line_ls", ls_b, 1);
               check_eq("b_line_fs", fs_b, 0);
               check_eq("b_line_vpos", vpos_b, 1);
            end
            479 * 8 + 7: begin
               check_eq("b_479_vpos", vpos_b, 479);
               check_eq("b_479_vis", vis_b, 0);
            end
            489 * 8 + 7: check_eq("b_vs489", vs_b, 1);
            490 * 8:     check_eq("b_vs490", vs_b, 0);
            491 * 8 + 7: check_eq("b_vs491", vs_b, 0);
            492 * 8:     check_eq("b_vs492", vs_b, 1);
            524 * 8 + 7: begin
               check_eq("b_524_vpos", vpos_b, 524);
               check_eq("b_524_fc", fc_b, 0);
            end
            4200: begin
               check_eq("b_frame_hpos", hpos_b, 0);
               check_eq("b_frame_vpos", vpos_b, 0);
               check_eq("b_frame_ls", ls_b, 1);
               check_eq("b_frame_fs", fs_b, 1);
               check_eq("b_frame_fc", fc_b, 1);
               check_eq("b_frame_vis", vis_b, 1);
            end
            4201: check_eq("b_fs_one_cycle", fs_b, 0);
            default: ;
         endcase
      end
      check_eq("b_vs_low_cycles", vs_low, 16);
      check_eq("b_line480_vis", vis_or, 0);
      rst_b = 1'b0;

      // ---- Instance c: frame counter wrap, then async reset ----
      rst_c = 1'b1;
      for (int k = 1; k <= 1025 * 32; k++) begin
         @(negedge clk);
         case (k)
            9:       check_eq("c_vis_1_1", vis_c, 1);
            16:      check_eq("c_vis_line2", vis_c, 0);
            23:      check_eq("c_vs_line2", vs_c, 1);
            24:      check_eq("c_vs_line3", vs_c, 0);
            1023 * 32: check_eq("c_fc1023", fc_c, 1023);
            1024 * 32: begin
               check_eq("c_fc_wrap0", fc_c, 0);
               check_eq("c_fc_wrap_fs", fs_c, 1);
            end
            1025 * 32: check_eq("c_fc_wrap1", fc_c, 1);
            default: ;
         endcase
      end
      repeat (11) @(negedge clk);
      check_eq("c_pre_rst_hpos", hpos_c, 3);
      check_eq("c_pre_rst_vpos", vpos_c, 1);
      #2 rst_c = 1'b0;
      #1;
      check_eq("c_async_hpos", hpos_c, 0);
      check_eq("c_async_vpos", vpos_c, 0);
      check_eq("c_async_fc", fc_c, 0);
      check_eq("c_async_vis", vis_c, 1);
      check_eq("c_async_hs", hs_c, 1);
      check_eq("c_async_ls", ls_c, 0);
      @(negedge clk);
      rst_c = 1'b1;
      @(negedge clk);
      check_eq("c_release_hpos", hpos_c, 1);
      check_eq("c_release_vpos", vpos_c, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
